// File: rtl/mips_cpu_hilo_muldiv_if.sv
// Request/result bundle between the datapath and the HI/LO multiply/divide unit.
// The datapath side uses the master modport, the unit uses the slave modport.
interface mips_cpu_hilo_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [4:0]            alu_op_i;
  logic [DATA_WIDTH-1:0] op_a_i;
  logic [DATA_WIDTH-1:0] op_b_i;
  logic                  hi_we_i;
  logic                  lo_we_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] hi_o;
  logic [DATA_WIDTH-1:0] lo_o;

  modport master (
    output start_i, alu_op_i, op_a_i, op_b_i, hi_we_i, lo_we_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, alu_op_i, op_a_i, op_b_i, hi_we_i, lo_we_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mips_cpu_hilo_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide run one bit per cycle on operand magnitudes.
module mips_cpu_hilo_muldiv #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] OP_MUL     = 5'd2,
  parameter logic [4:0] OP_DIV     = 5'd3,
  parameter logic [4:0] OP_MULU    = 5'd22,
  parameter logic [4:0] OP_DIVU    = 5'd23
) (
  input logic                   clk,
  input logic                   reset,
  mips_cpu_hilo_muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          neg_q, neg_d;
  logic          rem_neg_q, rem_neg_d;
  logic [W-1:0]  operand_q, operand_d;
  logic [W-1:0]  work_hi_q, work_hi_d;
  logic [W-1:0]  work_lo_q, work_lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          done_q, done_d;

  logic          op_valid, op_signed, op_div;
  logic [W-1:0]  abs_a, abs_b;

  always_comb begin
    op_valid  = (bus.alu_op_i == OP_MUL) || (bus.alu_op_i == OP_DIV) ||
                (bus.alu_op_i == OP_MULU) || (bus.alu_op_i == OP_DIVU);
    op_signed = (bus.alu_op_i == OP_MUL) || (bus.alu_op_i == OP_DIV);
    op_div    = (bus.alu_op_i == OP_DIV) || (bus.alu_op_i == OP_DIVU);
    abs_a     = (op_signed && bus.op_a_i[W-1]) ? -bus.op_a_i : bus.op_a_i;
    abs_b     = (op_signed && bus.op_b_i[W-1]) ? -bus.op_b_i : bus.op_b_i;
  end

  // Multiply keeps the product in {work_hi, work_lo} with the multiplier shifting out of
  // work_lo; divide keeps the partial remainder in work_hi and shifts the dividend out of work_lo.
  logic [W:0]     mul_sum;
  logic [W-1:0]   mul_hi, mul_lo;
  logic [W:0]     div_shift;
  logic           div_bit;
  logic [W-1:0]   div_diff, div_hi, div_lo;
  logic [2*W-1:0] prod_mag, prod_res;
  logic [W-1:0]   quo_res, rem_res;

  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : '0);
    mul_hi    = mul_sum[W:1];
    mul_lo    = {mul_sum[0], work_lo_q[W-1:1]};
    div_shift = {work_hi_q, work_lo_q[W-1]};
    div_bit   = div_shift >= {1'b0, operand_q};
    div_diff  = div_shift[W-1:0] - operand_q;
    div_hi    = div_bit ? div_diff : div_shift[W-1:0];
    div_lo    = {work_lo_q[W-2:0], div_bit};
    prod_mag  = {mul_hi, mul_lo};
    prod_res  = neg_q ? -prod_mag : prod_mag;
    quo_res   = neg_q ? -div_lo : div_lo;
    rem_res   = rem_neg_q ? -div_hi : div_hi;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    operand_d = operand_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && op_valid) begin
          state_d   = RUN;
          cnt_d     = '0;
          is_div_d  = op_div;
          neg_d     = op_signed && (bus.op_a_i[W-1] ^ bus.op_b_i[W-1]);
          rem_neg_d = op_signed && op_div && bus.op_a_i[W-1];
          operand_d = op_div ? abs_b : abs_a;
          work_hi_d = '0;
          work_lo_d = op_div ? abs_a : abs_b;
        end else begin
          if (bus.hi_we_i) hi_d = bus.op_a_i;
          if (bus.lo_we_i) lo_d = bus.op_a_i;
        end
      end
      RUN: begin
        work_hi_d = is_div_q ? div_hi : mul_hi;
        work_lo_d = is_div_q ? div_lo : mul_lo;
        cnt_d     = cnt_q + CW'(1);
        // The last iteration commits straight into HI/LO so partial results never show.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          hi_d    = is_div_q ? rem_res : prod_res[2*W-1:W];
          lo_d    = is_div_q ? quo_res : prod_res[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      operand_q <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      operand_q <= operand_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o = (state_q == RUN);
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Self-checking bench for mips_cpu_hilo_muldiv: directed corner cases plus randomized
// operations compared with a plain-arithmetic HI/LO reference model.
module tb_mips_cpu_hilo_muldiv;
  localparam int W = 32;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MULU = 5'd22;
  localparam logic [4:0] OP_DIVU = 5'd23;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [31:0] expHi, expLo;

  mips_cpu_hilo_muldiv_if #(.DATA_WIDTH(W)) bus ();

  mips_cpu_hilo_muldiv #(.DATA_WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} straight from the architectural definition.
  function automatic logic [63:0] refResult(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      OP_MULU: p = {32'd0, a} * {32'd0, b};
      OP_MUL:  p = sa * sb;
      OP_DIVU: if (b == 0) p = {a, 32'hFFFF_FFFF}; else p = {a % b, a / b};
      OP_DIV: begin
        if (b == 0) p = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start for one cycle and waits (bounded) for done; ends in the done cycle.
  task automatic issue_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output bit seen, output int busyCycles, output logic busyAtDone);
    bus.start_i  = 1'b1;
    bus.alu_op_i = op;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    tick(1);
    bus.start_i = 1'b0;
    seen        = 1'b0;
    busyCycles  = 0;
    busyAtDone  = 1'bx;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_o === 1'b1) begin
        seen       = 1'b1;
        busyAtDone = bus.busy_o;
        break;
      end
      if (bus.busy_o === 1'b1) busyCycles++;
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++;
    if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done_o); end
    checks++;
    if (bus.hi_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want 0", bus.hi_o); end
    checks++;
    if (bus.lo_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want 0", bus.lo_o); end
    reset = 1'b1;
    expHi = '0;
    expLo = '0;
    tick(1);
  endtask

  task automatic test_mthi_mtlo();
    bus.op_a_i  = 32'h1234_5678;
    bus.hi_we_i = 1'b1;
    tick(1);
    bus.hi_we_i = 1'b0;
    checks++;
    if (bus.hi_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mthi: got %h want 12345678", bus.hi_o); end
    checks++;
    if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL mthi_done: got %b want 0", bus.done_o); end
    bus.op_a_i  = 32'hCAFE_F00D;
    bus.lo_we_i = 1'b1;
    tick(1);
    bus.lo_we_i = 1'b0;
    checks++;
    if (bus.lo_o !== 32'hCAFE_F00D || bus.hi_o !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL mtlo: got hi=%h lo=%h want hi=12345678 lo=cafef00d", bus.hi_o, bus.lo_o);
    end
    bus.op_a_i  = 32'hA5A5_5A5A;
    bus.hi_we_i = 1'b1;
    bus.lo_we_i = 1'b1;
    tick(1);
    bus.hi_we_i = 1'b0;
    bus.lo_we_i = 1'b0;
    checks++;
    if (bus.hi_o !== 32'hA5A5_5A5A || bus.lo_o !== 32'hA5A5_5A5A) begin
      errors++; $display("[TB] FAIL mthi_mtlo_both: got hi=%h lo=%h want a5a55a5a", bus.hi_o, bus.lo_o);
    end
    expHi = 32'hA5A5_5A5A;
    expLo = 32'hA5A5_5A5A;
  endtask

  task automatic test_directed_table(input vec_t v [5], input int n, input bit pulseCheck);
    bit seen;
    int busyCycles;
    logic busyAtDone;
    for (int i = 0; i < n; i++) begin
      issue_op(v[i].op, v[i].a, v[i].b, seen, busyCycles, busyAtDone);
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL dir%0d_op%0d_done: no done within bound, want pulse", i, v[i].op); end
      checks++;
      if (busyCycles != 32) begin errors++; $display("[TB] FAIL dir%0d_busy_len: got %0d want 32", i, busyCycles); end
      checks++;
      if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_busy_at_done: got %b want 0", i, busyAtDone); end
      checks++;
      if (bus.hi_o !== v[i].hi || bus.lo_o !== v[i].lo) begin
        errors++; $display("[TB] FAIL dir%0d_result: got hi=%h lo=%h want hi=%h lo=%h", i, bus.hi_o, bus.lo_o, v[i].hi, v[i].lo);
      end
      expHi = v[i].hi;
      expLo = v[i].lo;
      if (pulseCheck) begin
        tick(1);
        checks++;
        if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_width: got %b want 0", i, bus.done_o); end
      end
    end
  endtask

  task automatic test_multiply();
    vec_t v [5];
    v[0] = '{OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[1] = '{OP_MUL,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[2] = '{OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    v[3] = '{OP_MULU, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C};
    v[4] = '{OP_MUL,  32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    test_directed_table(v, 5, 1'b1);
  endtask

  task automatic test_divide();
    vec_t v [5];
    v[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[1] = '{OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
    v[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    v[3] = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    v[4] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    test_directed_table(v, 5, 1'b0);
  endtask

  task automatic test_divide_by_zero();
    vec_t v [5];
    v[0] = '{OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    v[1] = '{OP_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001};
    v[2] = '{OP_DIV,  32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF};
    v[3] = '{OP_DIVU, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF};
    v[4] = '{OP_DIVU, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    test_directed_table(v, 5, 1'b1);
  endtask

  task automatic test_invalid_op();
    logic [4:0] badOps [4] = '{5'd0, 5'd1, 5'd4, 5'd21};
    bit active;
    for (int k = 0; k < 4; k++) begin
      active       = 1'b0;
      bus.alu_op_i = badOps[k];
      bus.op_a_i   = $urandom;
      bus.op_b_i   = $urandom;
      bus.start_i  = 1'b1;
      tick(2);
      bus.start_i = 1'b0;
      for (int i = 0; i < 36; i++) begin
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) active = 1'b1;
        tick(1);
      end
      checks++;
      if (active) begin errors++; $display("[TB] FAIL invalid_op%0d: got busy/done activity, want none", badOps[k]); end
    end
    checks++;
    if (bus.hi_o !== expHi || bus.lo_o !== expLo) begin
      errors++; $display("[TB] FAIL invalid_hold: got hi=%h lo=%h want hi=%h lo=%h", bus.hi_o, bus.lo_o, expHi, expLo);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    logic [63:0] exp;
    bit seen, visibleOk;
    int busyCycles;
    a   = $urandom | 32'h0001_0000;
    b   = $urandom | 32'h0000_0100;
    exp = refResult(OP_MULU, a, b);
    bus.alu_op_i = OP_MULU;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    bus.start_i  = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    seen       = 1'b0;
    visibleOk  = 1'b1;
    busyCycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy_o === 1'b1) busyCycles++;
      if (bus.hi_o !== expHi || bus.lo_o !== expLo) visibleOk = 1'b0;
      if (i == 4) begin
        bus.start_i  = 1'b1;
        bus.alu_op_i = OP_DIVU;
        bus.op_a_i   = $urandom;
        bus.op_b_i   = $urandom;
        bus.hi_we_i  = 1'b1;
        bus.lo_we_i  = 1'b1;
      end else begin
        bus.start_i = 1'b0;
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
      end
      if (i == 10) begin
        bus.op_a_i = ~a;
        bus.op_b_i = ~b;
      end
      tick(1);
    end
    bus.start_i = 1'b0;
    bus.hi_we_i = 1'b0;
    bus.lo_we_i = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL busy_ignore_done: no done within bound, want pulse"); end
    checks++;
    if (busyCycles != 32) begin errors++; $display("[TB] FAIL busy_ignore_len: got %0d want 32", busyCycles); end
    checks++;
    if (!visibleOk) begin errors++; $display("[TB] FAIL busy_ignore_hold: got hi/lo change mid-run, want hi=%h lo=%h", expHi, expLo); end
    checks++;
    if ({bus.hi_o, bus.lo_o} !== exp) begin
      errors++; $display("[TB] FAIL busy_ignore_result: got %h%h want %h", bus.hi_o, bus.lo_o, exp);
    end
    expHi = exp[63:32];
    expLo = exp[31:0];
    tick(3);
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL busy_ignore_no_restart: got busy %b want 0", bus.busy_o); end
  endtask

  task automatic test_start_with_we();
    bit seen;
    bus.op_a_i  = 32'hDEAD_BEEF;
    bus.hi_we_i = 1'b1;
    bus.lo_we_i = 1'b1;
    tick(1);
    bus.alu_op_i = OP_MULU;
    bus.op_a_i   = 32'h0000_1234;
    bus.op_b_i   = 32'h0000_0010;
    bus.start_i  = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    bus.hi_we_i = 1'b0;
    bus.lo_we_i = 1'b0;
    checks++;
    if (bus.hi_o !== 32'hDEAD_BEEF || bus.lo_o !== 32'hDEAD_BEEF || bus.busy_o !== 1'b1) begin
      errors++; $display("[TB] FAIL start_wins: got hi=%h lo=%h busy=%b want deadbeef deadbeef 1", bus.hi_o, bus.lo_o, bus.busy_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    checks++;
    if (!seen || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0001_2340) begin
      errors++; $display("[TB] FAIL start_wins_result: got done=%b hi=%h lo=%h want 1 0 00012340", seen, bus.hi_o, bus.lo_o);
    end
    expHi = 32'h0;
    expLo = 32'h0001_2340;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] exp1, exp2;
    bit seen;
    int busyCycles;
    logic busyAtDone;
    a1   = $urandom;
    b1   = $urandom;
    a2   = $urandom;
    b2   = $urandom_range(1, 1000);
    exp1 = refResult(OP_MUL, a1, b1);
    exp2 = refResult(OP_DIVU, a2, b2);
    issue_op(OP_MUL, a1, b1, seen, busyCycles, busyAtDone);
    checks++;
    if (!seen || {bus.hi_o, bus.lo_o} !== exp1) begin
      errors++; $display("[TB] FAIL b2b_first: got done=%b %h%h want 1 %h", seen, bus.hi_o, bus.lo_o, exp1);
    end
    issue_op(OP_DIVU, a2, b2, seen, busyCycles, busyAtDone);
    checks++;
    if (!seen || busyCycles != 32) begin
      errors++; $display("[TB] FAIL b2b_second_timing: got done=%b busy=%0d want 1 32", seen, busyCycles);
    end
    checks++;
    if ({bus.hi_o, bus.lo_o} !== exp2) begin
      errors++; $display("[TB] FAIL b2b_second_result: got %h%h want %h", bus.hi_o, bus.lo_o, exp2);
    end
    expHi = exp2[63:32];
    expLo = exp2[31:0];
  endtask

  task automatic test_random();
    logic [4:0] ops [4] = '{OP_MUL, OP_DIV, OP_MULU, OP_DIVU};
    logic [4:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    bit seen;
    int busyCycles;
    logic busyAtDone;
    for (int n = 0; n < 24; n++) begin
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = $urandom_range(1, 9);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = refResult(op, a, b);
      issue_op(op, a, b, seen, busyCycles, busyAtDone);
      checks++;
      if (!seen || busyCycles != 32 || busyAtDone !== 1'b0) begin
        errors++; $display("[TB] FAIL rand%0d_timing: got done=%b busy=%0d busyAtDone=%b want 1 32 0", n, seen, busyCycles, busyAtDone);
      end
      checks++;
      if ({bus.hi_o, bus.lo_o} !== exp) begin
        errors++; $display("[TB] FAIL rand%0d_op%0d a=%h b=%h: got %h%h want %h", n, op, a, b, bus.hi_o, bus.lo_o, exp);
      end
      expHi = exp[63:32];
      expLo = exp[31:0];
      tick($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_abort();
    bit active, seen;
    int busyCycles;
    logic busyAtDone;
    bus.alu_op_i = OP_DIV;
    bus.op_a_i   = $urandom;
    bus.op_b_i   = $urandom_range(1, 100);
    bus.start_i  = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    tick(9);
    reset = 1'b0;
    tick(1);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_ctrl: got busy=%b done=%b want 0 0", bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
      errors++; $display("[TB] FAIL abort_hilo: got hi=%h lo=%h want 0 0", bus.hi_o, bus.lo_o);
    end
    reset  = 1'b1;
    active = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) active = 1'b1;
    end
    checks++;
    if (active) begin errors++; $display("[TB] FAIL abort_no_done: got activity after abort, want none"); end
    issue_op(OP_MULU, 32'd3, 32'd4, seen, busyCycles, busyAtDone);
    checks++;
    if (!seen || busyCycles != 32 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'd12) begin
      errors++; $display("[TB] FAIL abort_recover: got done=%b busy=%0d hi=%h lo=%h want 1 32 0 c", seen, busyCycles, bus.hi_o, bus.lo_o);
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.start_i  = 1'b0;
    bus.alu_op_i = '0;
    bus.op_a_i   = '0;
    bus.op_b_i   = '0;
    bus.hi_we_i  = 1'b0;
    bus.lo_we_i  = 1'b0;
    expHi        = '0;
    expLo        = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_mthi_mtlo();
    test_multiply();
    test_divide();
    test_divide_by_zero();
    test_invalid_op();
    test_busy_ignore();
    test_start_with_we();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
